// File: rtl/ccff_loader.sv
// ccff_loader: streams bitstream words LSB-first into a ccff configuration chain,
// then releases I/O isolation once exactly CHAIN_LEN bits have been clocked in.
module ccff_loader #(
    parameter int CHAIN_LEN = 4,
    parameter int DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    output logic              isol_n,
    output logic              busy,
    output logic              done
);
    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    localparam int SC_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            r_state;
    logic [BL_W-1:0]   r_bits_left;
    logic [SC_W-1:0]   r_sh_cnt;
    logic [DATA_W-1:0] r_sh;
    logic              r_head;
    logic              w_shift;
    logic [SC_W-1:0]   w_take;

    assign w_shift      = r_sh_cnt != '0;
    // the final word is truncated to the bits the chain still needs
    assign w_take       = (32'(r_bits_left) > DATA_W) ? SC_W'(DATA_W) : SC_W'(r_bits_left);
    assign bs_ready     = (r_state == LOAD) && !w_shift && (r_bits_left != '0);
    assign ccff_head    = w_shift ? r_sh[0] : r_head;
    assign chain_clk_en = w_shift;
    assign busy         = r_state == LOAD;
    assign done         = r_state == DONE;
    assign isol_n       = r_state == DONE;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state     <= IDLE;
            r_bits_left <= '0;
            r_sh_cnt    <= '0;
            r_sh        <= '0;
            r_head      <= 1'b0;
        end else if (r_state != LOAD && start) begin
            r_state     <= LOAD;
            r_bits_left <= BL_W'(CHAIN_LEN);
            r_sh_cnt    <= '0;
        end else if (r_state == LOAD) begin
            if (w_shift) begin
                r_head      <= r_sh[0];
                r_sh        <= r_sh >> 1;
                r_sh_cnt    <= r_sh_cnt - 1'b1;
                r_bits_left <= r_bits_left - 1'b1;
                if (r_bits_left == BL_W'(1)) r_state <= DONE;
            end else if (bs_valid && bs_ready) begin
                r_sh     <= bs_data;
                r_sh_cnt <= w_take;
            end
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed checks of ccff_loader with a 4-bit and a 12-bit chain
// driven from shared stimulus; sel picks which instance a scenario observes.
module tb_ccff_loader;
    logic       prog_clk = 1'b0;
    logic       prog_reset, start, bs_valid;
    logic [7:0] bs_data;
    logic       rdy4, head4, en4, iso4, busy4, done4;
    logic       rdy12, head12, en12, iso12, busy12, done12;
    logic       sel;
    logic       m_rdy, m_head, m_en, m_iso, m_busy, m_done;
    int         vec = 0, errs = 0;
    logic [15:0] bits;
    int         nbits, acc, gap, hold_err, rdy_err;

    always #5 prog_clk = ~prog_clk;

    ccff_loader #(.CHAIN_LEN(4), .DATA_W(8)) u4 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .bs_data(bs_data),
        .bs_valid(bs_valid), .bs_ready(rdy4), .ccff_head(head4), .chain_clk_en(en4),
        .isol_n(iso4), .busy(busy4), .done(done4));

    ccff_loader #(.CHAIN_LEN(12), .DATA_W(8)) u12 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .bs_data(bs_data),
        .bs_valid(bs_valid), .bs_ready(rdy12), .ccff_head(head12), .chain_clk_en(en12),
        .isol_n(iso12), .busy(busy12), .done(done12));

    assign m_rdy  = sel ? rdy12  : rdy4;
    assign m_head = sel ? head12 : head4;
    assign m_en   = sel ? en12   : en4;
    assign m_iso  = sel ? iso12  : iso4;
    assign m_busy = sel ? busy12 : busy4;
    assign m_done = sel ? done12 : done4;

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Runs one load on the selected instance and records what the chain saw.
    task automatic drive_load(input bit do_start, input logic [7:0] w0, input logic [7:0] w1,
                              input int stall, input int start_at);
        int cl, st;
        logic last;
        cl = sel ? 12 : 4;
        st = 0;
        bits = '0; nbits = 0; acc = 0; gap = 0; hold_err = 0; rdy_err = 0;
        bs_data = w0;
        bs_valid = 1'b1;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        last = m_head;
        for (int c = 0; c < 60; c++) begin
            if (m_done) break;
            start = (c == start_at);
            if (acc == 1 && m_rdy && st < stall) begin
                bs_valid = 1'b0;
                st++;
            end else bs_valid = 1'b1;
            if (m_en) begin
                bits[nbits] = m_head;
                nbits++;
                last = m_head;
            end else begin
                if (m_head !== last) hold_err++;
                if (nbits > 0) gap++;
            end
            if (acc * 8 >= cl && m_rdy) rdy_err++;
            if (bs_valid && m_rdy) acc++;
            tick();
            bs_data = (acc >= 1) ? w1 : w0;
        end
        start = 1'b0;
        bs_valid = 1'b0;
    endtask

    task automatic test_reset();
        prog_reset = 1'b1; start = 1'b1; bs_valid = 1'b1; bs_data = 8'hFF;
        tick();
        tick();
        vec++;
        if ({head4, en4, iso4, busy4, done4, rdy4} !== 6'b0) begin
            errs++; $display("FAIL reset4 got %b want 000000", {head4, en4, iso4, busy4, done4, rdy4});
        end
        vec++;
        if ({head12, en12, iso12, busy12, done12, rdy12} !== 6'b0) begin
            errs++; $display("FAIL reset12 got %b want 000000", {head12, en12, iso12, busy12, done12, rdy12});
        end
        prog_reset = 1'b0; start = 1'b0; bs_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        sel = 1'b0;
        drive_load(1'b1, 8'hA5, 8'hA5, 0, 3);
        vec++;
        if (bits[3:0] !== 4'h5) begin errs++; $display("FAIL single_bits got %h want 5", bits[3:0]); end
        vec++;
        if (nbits !== 4) begin errs++; $display("FAIL single_enables got %0d want 4", nbits); end
        vec++;
        if (acc !== 1) begin errs++; $display("FAIL single_accepts got %0d want 1", acc); end
        vec++;
        if (gap !== 0 || hold_err !== 0 || rdy_err !== 0) begin
            errs++; $display("FAIL single_gap_hold_rdy got %0d/%0d/%0d want 0/0/0", gap, hold_err, rdy_err);
        end
        vec++;
        if ({m_done, m_iso, m_busy, m_en} !== 4'b1100) begin
            errs++; $display("FAIL single_done_state got %b want 1100", {m_done, m_iso, m_busy, m_en});
        end
    endtask

    task automatic test_restart();
        sel = 1'b0;
        bs_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        vec++;
        if ({m_iso, m_done, m_busy} !== 3'b001) begin
            errs++; $display("FAIL restart_state got %b want 001", {m_iso, m_done, m_busy});
        end
        drive_load(1'b0, 8'h0A, 8'h0A, 0, 1);
        vec++;
        if (bits[3:0] !== 4'hA || nbits !== 4) begin
            errs++; $display("FAIL restart_bits got %h/%0d want a/4", bits[3:0], nbits);
        end
        tick();
        vec++;
        if ({m_head, m_en, m_done} !== 3'b101) begin
            errs++; $display("FAIL restart_hold got %b want 101", {m_head, m_en, m_done});
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        drive_load(1'b1, 8'h3C, 8'h0F, 0, -1);
        vec++;
        if (bits[11:0] !== 12'hF3C) begin errs++; $display("FAIL b2b_bits got %h want f3c", bits[11:0]); end
        vec++;
        if (nbits !== 12 || acc !== 2) begin
            errs++; $display("FAIL b2b_counts got %0d/%0d want 12/2", nbits, acc);
        end
        vec++;
        if (gap !== 1 || hold_err !== 0 || rdy_err !== 0) begin
            errs++; $display("FAIL b2b_gap_hold_rdy got %0d/%0d/%0d want 1/0/0", gap, hold_err, rdy_err);
        end
        vec++;
        if ({m_done, m_iso, m_busy, m_en} !== 4'b1100) begin
            errs++; $display("FAIL b2b_done_state got %b want 1100", {m_done, m_iso, m_busy, m_en});
        end
    endtask

    task automatic test_stall();
        sel = 1'b1;
        drive_load(1'b1, 8'h3C, 8'h0F, 5, -1);
        vec++;
        if (bits[11:0] !== 12'hF3C || nbits !== 12) begin
            errs++; $display("FAIL stall_bits got %h/%0d want f3c/12", bits[11:0], nbits);
        end
        vec++;
        if (gap !== 6 || hold_err !== 0) begin
            errs++; $display("FAIL stall_gap_hold got %0d/%0d want 6/0", gap, hold_err);
        end
        vec++;
        if (m_done !== 1'b1) begin errs++; $display("FAIL stall_done got %b want 1", m_done); end
    endtask

    task automatic test_mid_reset();
        int pulses;
        sel = 1'b1;
        bs_data = 8'h3C; bs_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        bs_valid = 1'b0;
        tick();
        prog_reset = 1'b1; start = 1'b1; bs_valid = 1'b1;
        tick();
        prog_reset = 1'b0; start = 1'b0; bs_valid = 1'b0;
        vec++;
        if ({head12, en12, iso12, busy12, done12, rdy12} !== 6'b0) begin
            errs++; $display("FAIL midreset_state got %b want 000000", {head12, en12, iso12, busy12, done12, rdy12});
        end
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (en12) pulses++;
            tick();
        end
        vec++;
        if (pulses !== 0) begin errs++; $display("FAIL midreset_enables got %0d want 0", pulses); end
        drive_load(1'b1, 8'h3C, 8'h0F, 0, -1);
        vec++;
        if (bits[11:0] !== 12'hF3C || nbits !== 12) begin
            errs++; $display("FAIL midreset_reload got %h/%0d want f3c/12", bits[11:0], nbits);
        end
    endtask

    initial begin
        sel = 1'b0; prog_reset = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
        test_reset();
        test_single_word();
        test_restart();
        prog_reset = 1'b1; tick(); prog_reset = 1'b0;
        test_back_to_back();
        prog_reset = 1'b1; tick(); prog_reset = 1'b0;
        test_stall();
        prog_reset = 1'b1; tick(); prog_reset = 1'b0;
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 4: total configuration bits in the downstream ccff chain.
REQ-002 SHALL have parameter DATA_W, default 8: bitstream word width.
REQ-003 SHALL have prog_clk  input  1  the one clock; all state updates on its rising edge.
REQ-004 SHALL have prog_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have start  input  1  begin a load; sampled only in IDLE or DONE.
REQ-006 SHALL have bs_data  input  DATA_W  bitstream word; bit 0 is shifted first.
REQ-007 SHALL have bs_valid  input  1  bs_data valid.
REQ-008 SHALL have bs_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have ccff_head  output  1  serial config bit driven into the chain head.
REQ-010 SHALL have chain_clk_en  output  1  high exactly in cycles where ccff_head carries a valid bit; gates prog_clk to the chain.
REQ-011 SHALL have isol_n  output  1  I/O isolation release; 0 means pads isolated.
REQ-012 SHALL have busy  output  1  high in LOAD.
REQ-013 SHALL have done  output  1  high in DONE.

Function
REQ-014 SHALL implement states IDLE, LOAD and DONE.
REQ-015 Transitions SHALL be: IDLE->LOAD on start; LOAD->DONE after the CHAIN_LEN-th bit is presented; DONE->LOAD on start; otherwise hold.
REQ-016 Entering LOAD SHALL set bits_left=CHAIN_LEN (width clog2(CHAIN_LEN+1)) and sh_cnt=0.
REQ-017 bs_ready SHALL be combinational: (state==LOAD) && (sh_cnt==0) && (bits_left!=0).
REQ-018 A word SHALL be accepted only in a cycle with bs_valid && bs_ready.
REQ-019 On acceptance, the loader SHALL load the shift register with the word and set sh_cnt=min(DATA_W, bits_left).
REQ-020 In each cycle with sh_cnt!=0, ccff_head SHALL present the current shift-register LSB and chain_clk_en SHALL be 1; on the following edge the loader SHALL shift right, decrement sh_cnt and decrement bits_left.
REQ-021 Timing SHALL be: word accepted at edge N; bit0 presented in cycle N+1; bits presented in consecutive cycles through N+k, where k=min(DATA_W, bits_left).
REQ-022 In every cycle with sh_cnt==0, chain_clk_en SHALL be 0 and ccff_head SHALL hold its last value; this includes the one-cycle bubble between words and bs_valid stalls.
REQ-023 Bits of the final word beyond bits_left SHALL be discarded and never presented.
REQ-024 After the last bit is presented, the next cycle SHALL show state DONE, done=1, busy=0, isol_n=1, chain_clk_en=0.
REQ-025 isol_n SHALL be 0 in IDLE and LOAD and 1 only in DONE.
REQ-026 start while in LOAD SHALL be ignored.
REQ-027 start in DONE SHALL restart a full load; isol_n SHALL drop to 0 on the next cycle.
REQ-028 Total chain_clk_en-high cycles per load SHALL equal CHAIN_LEN exactly.

Reset
REQ-029 On prog_reset=1 at an edge, the next cycle SHALL show: state IDLE, ccff_head=0, chain_clk_en=0, isol_n=0, busy=0, done=0, bs_ready=0, sh_cnt=0, bits_left=0.
REQ-030 Reset mid-LOAD SHALL abort the load with no further chain_clk_en pulses; a new start is required.
REQ-031 prog_reset SHALL take priority over start and over a handshake in the same cycle.

Verification
REQ-032 CHAIN_LEN=4, DATA_W=8, bs_data=8'hA5 with bs_valid held: 1 accept; ccff_head sequence 1,0,1,0 with chain_clk_en=1 for 4 cycles; then done=1 and isol_n=1; the upper nibble is never presented.
REQ-033 CHAIN_LEN=12, DATA_W=8, words 8'h3C then 8'h0F: 8 bits, then 1 bubble cycle, then 4 bits (1,1,1,1); exactly 12 enabled cycles; bs_ready=0 after the second accept.
REQ-034 CHAIN_LEN=12, bs_valid dropped for 5 cycles after the first word: chain_clk_en=0 throughout the stall; ccff_head holds its value; the load completes correctly once bs_valid returns.
REQ-035 prog_reset pulsed after 2 bits presented: next cycle IDLE with all outputs at reset values; no further enables; a later start loads all CHAIN_LEN bits from the beginning.
REQ-036 start pulsed in LOAD and again in DONE: the LOAD pulse has no effect; the DONE pulse returns the block to LOAD with isol_n=0, done=0, busy=1.
